// File: rtl/shift_align_2048_pkg.sv
// Shared constants and FSM state encoding for the 2048-bit word-serial left shifter.
package shift_align_2048_pkg;

   localparam int WORD_W    = 32;
   localparam int NUM_WORDS = 64;
   localparam int IDX_W     = 6;
   localparam int LEN_W     = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SKIP  = 2'd1,
      SHIFT = 2'd2,
      PAD   = 2'd3
   } state_t;

endpackage

// File: rtl/shift_align_2048_funnel_shift32.sv
// Combinational 32-bit funnel: (hi << r) | (lo >> (32 - r)); r == 0 passes hi unchanged.
module funnel_shift32
   import shift_align_2048_pkg::*;
(
   input  logic [WORD_W-1:0] iHi,
   input  logic [WORD_W-1:0] iLo,
   input  logic [4:0]        iR,
   output logic [WORD_W-1:0] oY
);

   logic [5:0] w_rsh;

   assign w_rsh = 6'd32 - {1'b0, iR};
   assign oY    = (iR == 5'd0) ? iHi : ((iHi << iR) | (iLo >> w_rsh));

endmodule

// File: rtl/shift_align_2048.sv
// Word-serial left shift of a 2048-bit operand (64 x 32-bit words, MSW first) by a 12-bit length.
// Optional build macro SHIFT_ALIGN_OVF_EN adds the sticky per-frame oOverflow output.
module shift_align_2048
   import shift_align_2048_pkg::*;
(
   input  logic              iClk,
   input  logic              iReset_n,
   input  logic              iStart,
   input  logic [LEN_W-1:0]  iLength,
   input  logic              iValid,
   input  logic [WORD_W-1:0] iData,
   output logic              oValid,
   output logic [WORD_W-1:0] oData,
   output logic              oLast,
   output logic              oBusy,
   output logic              oFinish,
`ifdef SHIFT_ALIGN_OVF_EN
   output logic              oOverflow,
`endif
   output state_t            oDbgState
);

   // Handshake: a word is taken on any cycle with iValid high while in SKIP/SHIFT;
   // there is no back-pressure, and oValid marks each registered output word for one cycle.

   state_t            r_state;
   state_t            w_next;
   logic [IDX_W-1:0]  r_q;
   logic [4:0]        r_r;
   logic              r_all;
   logic [IDX_W-1:0]  r_jcnt;
   logic [IDX_W-1:0]  r_ocnt;
   logic              r_pad_first;
   logic [WORD_W-1:0] r_hold;
   logic              r_valid;
   logic [WORD_W-1:0] r_data;
   logic              r_last;
   logic              r_finish;

   logic              w_start;
   logic              w_accept;
   logic              w_emit;
   logic [WORD_W-1:0] w_emit_data;
   logic [WORD_W-1:0] w_funnel_lo;
   logic [WORD_W-1:0] w_funnel_y;

   assign w_start     = (r_state == IDLE) && iStart;
   assign w_accept    = iValid && ((r_state == SKIP) || (r_state == SHIFT));
   assign w_funnel_lo = (r_state == PAD) ? '0 : iData;

   funnel_shift32 u_funnel (
      .iHi (r_hold),
      .iLo (w_funnel_lo),
      .iR  (r_r),
      .oY  (w_funnel_y)
   );

   always_ff @(posedge iClk) begin
      if (!iReset_n) r_state <= IDLE;
      else           r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:  if (iStart) w_next = (iLength[11] || (iLength[10:5] != '0)) ? SKIP : SHIFT;
         SKIP:  if (iValid) begin
                   if (r_all) begin
                      if (r_jcnt == 6'd63) w_next = PAD;
                   end else if (r_jcnt == (r_q - 6'd1)) begin
                      w_next = SHIFT;
                   end
                end
         SHIFT: if (iValid && (r_jcnt == 6'd63)) w_next = PAD;
         PAD:   if (r_ocnt == 6'd63) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Word q only primes the hold register; every later word releases one funnelled word.
   always_comb begin
      w_emit      = 1'b0;
      w_emit_data = '0;
      case (r_state)
         SHIFT: if (iValid && (r_jcnt != r_q)) begin
                   w_emit      = 1'b1;
                   w_emit_data = w_funnel_y;
                end
         PAD:   begin
                   w_emit      = 1'b1;
                   w_emit_data = (r_pad_first && !r_all) ? w_funnel_y : '0;
                end
         default: ;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         r_q         <= '0;
         r_r         <= '0;
         r_all       <= 1'b0;
         r_jcnt      <= '0;
         r_ocnt      <= '0;
         r_pad_first <= 1'b0;
         r_hold      <= '0;
         r_valid     <= 1'b0;
         r_data      <= '0;
         r_last      <= 1'b0;
         r_finish    <= 1'b0;
      end else begin
         r_valid  <= w_emit;
         r_data   <= w_emit_data;
         r_last   <= w_emit && (r_ocnt == 6'd63);
         r_finish <= w_emit && (r_ocnt == 6'd63);
         if (w_start) begin
            r_q         <= iLength[10:5];
            r_r         <= iLength[4:0];
            r_all       <= iLength[11];
            r_jcnt      <= '0;
            r_ocnt      <= '0;
            r_pad_first <= 1'b1;
            r_hold      <= '0;
         end
         if (w_accept) begin
            r_jcnt <= r_jcnt + 6'd1;
            if (r_state == SHIFT) r_hold <= iData;
         end
         if (w_emit) r_ocnt <= r_ocnt + 6'd1;
         if (r_state == PAD) r_pad_first <= 1'b0;
      end
   end

`ifdef SHIFT_ALIGN_OVF_EN
   logic              r_ovf;
   logic [WORD_W-1:0] w_top_mask;

   // Bits of W[q] that the left shift pushes past the operand's top edge.
   assign w_top_mask = ~(32'hFFFF_FFFF >> r_r);

   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         r_ovf <= 1'b0;
      end else if (w_start) begin
         r_ovf <= 1'b0;
      end else if (w_accept) begin
         if ((r_state == SKIP) && (iData != '0))
            r_ovf <= 1'b1;
         if ((r_state == SHIFT) && (r_jcnt == r_q) && ((iData & w_top_mask) != '0))
            r_ovf <= 1'b1;
      end
   end

   assign oOverflow = r_ovf;
`endif

   assign oValid    = r_valid;
   assign oData     = r_data;
   assign oLast     = r_last;
   assign oFinish   = r_finish;
   assign oBusy     = (r_state != IDLE);
   assign oDbgState = r_state;

endmodule

// File: tb/tb_shift_align_2048.sv
// Directed bench for shift_align_2048: fixed shift lengths with hand-computed word streams,
// plus a gapped frame interrupted by reset and a follow-up frame.
module tb_shift_align_2048;
   import shift_align_2048_pkg::*;

   logic        iClk;
   logic        iReset_n;
   logic        iStart;
   logic [11:0] iLength;
   logic        iValid;
   logic [31:0] iData;
   logic        oValid;
   logic [31:0] oData;
   logic        oLast;
   logic        oBusy;
   logic        oFinish;
`ifdef SHIFT_ALIGN_OVF_EN
   logic        oOverflow;
`endif
   state_t      oDbgState;

   shift_align_2048 dut (
      .iClk      (iClk),
      .iReset_n  (iReset_n),
      .iStart    (iStart),
      .iLength   (iLength),
      .iValid    (iValid),
      .iData     (iData),
      .oValid    (oValid),
      .oData     (oData),
      .oLast     (oLast),
      .oBusy     (oBusy),
      .oFinish   (oFinish),
`ifdef SHIFT_ALIGN_OVF_EN
      .oOverflow (oOverflow),
`endif
      .oDbgState (oDbgState)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [31:0] in_w [64];
   logic [31:0] exp_q [$];
   logic [31:0] got_q [$];
   int          last_cnt = 0;
   int          last_pos = 0;
   int          fin_cnt  = 0;
   logic        ovf_at_fin = 1'b0;

   always @(negedge iClk) begin
      if (oValid) begin
         got_q.push_back(oData);
         if (oLast) begin
            last_cnt++;
            last_pos = got_q.size();
         end
      end
      if (oFinish) begin
         fin_cnt++;
`ifdef SHIFT_ALIGN_OVF_EN
         ovf_at_fin = oOverflow;
`endif
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int gap_max);
      int g;
      g = $urandom_range(0, gap_max);
      repeat (g) begin
         iValid = 1'b0;
         @(posedge iClk); #1;
      end
      iValid = 1'b1;
      iData  = w;
      @(posedge iClk); #1;
      iValid = 1'b0;
      iData  = '0;
   endtask

   task automatic start_frame(input logic [11:0] len);
      got_q.delete();
      last_cnt   = 0;
      last_pos   = 0;
      fin_cnt    = 0;
      ovf_at_fin = 1'b0;
      iStart  = 1'b1;
      iLength = len;
      @(posedge iClk); #1;
      iStart  = 1'b0;
      @(negedge iClk);
      check("busy_after_start", {31'd0, oBusy}, 32'd1);
      @(posedge iClk); #1;
   endtask

   task automatic run_frame(input string name, input logic [11:0] len, input int gap_max);
      int k;
      start_frame(len);
      for (int j = 0; j < 64; j++) send_word(in_w[j], gap_max);
      k = 0;
      while (fin_cnt == 0 && k < 400) begin
         @(negedge iClk);
         k++;
      end
      repeat (2) @(negedge iClk);
      check({name, "_count"}, got_q.size(), 32'd64);
      for (int i = 0; i < 64; i++)
         if (i < got_q.size())
            check($sformatf("%s_w%0d", name, i), got_q[i], exp_q[i]);
      check({name, "_last_cnt"}, last_cnt, 32'd1);
      check({name, "_last_pos"}, last_pos, 32'd64);
      check({name, "_finish_cnt"}, fin_cnt, 32'd1);
      check({name, "_busy_end"}, {31'd0, oBusy}, 32'd0);
      check({name, "_state_end"}, {30'd0, oDbgState}, {30'd0, IDLE});
      @(posedge iClk); #1;
   endtask

   initial begin
      iReset_n = 1'b0;
      iStart   = 1'b0;
      iLength  = '0;
      iValid   = 1'b0;
      iData    = '0;
      repeat (3) @(posedge iClk);
      #1;
      @(negedge iClk);
      check("rst_valid",  {31'd0, oValid},  32'd0);
      check("rst_data",   oData,            32'd0);
      check("rst_last",   {31'd0, oLast},   32'd0);
      check("rst_busy",   {31'd0, oBusy},   32'd0);
      check("rst_finish", {31'd0, oFinish}, 32'd0);
      check("rst_state",  {30'd0, oDbgState}, {30'd0, IDLE});
      iReset_n = 1'b1;
      @(posedge iClk); #1;

      // L=0: stream passes through unchanged
      exp_q.delete();
      for (int j = 0; j < 64; j++) begin
         in_w[j] = 32'(j + 1);
         exp_q.push_back(32'(j + 1));
      end
      run_frame("l0", 12'd0, 0);

      // L=4 over 0x80000001: each word picks up the 0x8 nibble from its neighbour
      exp_q.delete();
      for (int j = 0; j < 64; j++) in_w[j] = 32'h8000_0001;
      for (int i = 0; i < 63; i++) exp_q.push_back(32'h0000_0018);
      exp_q.push_back(32'h0000_0010);
      run_frame("l4", 12'd4, 1);

      // L=32 with W[j]=j: one-word skip, zero tail, W[0]=0 so nothing is lost
      exp_q.delete();
      for (int j = 0; j < 64; j++) in_w[j] = 32'(j);
      for (int i = 0; i < 63; i++) exp_q.push_back(32'(i + 1));
      exp_q.push_back(32'h0);
      run_frame("l32", 12'd32, 0);
`ifdef SHIFT_ALIGN_OVF_EN
      check("l32_ovf", {31'd0, ovf_at_fin}, 32'd0);
`endif

      // L=2047: only W[63] bit 0 survives, landing at the top of out[0]
      exp_q.delete();
      for (int j = 0; j < 64; j++) in_w[j] = (j == 63) ? 32'h1 : 32'h0;
      exp_q.push_back(32'h8000_0000);
      for (int i = 1; i < 64; i++) exp_q.push_back(32'h0);
      run_frame("l2047", 12'd2047, 0);
`ifdef SHIFT_ALIGN_OVF_EN
      check("l2047_ovf", {31'd0, ovf_at_fin}, 32'd0);
`endif

      // L=3000: beyond the operand, all zeros
      exp_q.delete();
      for (int j = 0; j < 64; j++) begin
         in_w[j] = 32'(j + 1);
         exp_q.push_back(32'h0);
      end
      run_frame("l3000", 12'd3000, 1);
`ifdef SHIFT_ALIGN_OVF_EN
      check("l3000_ovf", {31'd0, ovf_at_fin}, 32'd1);
`endif

      // L=0 frame with gaps, an ignored mid-frame iStart, then reset after word 29
      start_frame(12'd0);
      for (int j = 0; j < 30; j++) begin
         in_w[j] = 32'(j * 3 + 7);
         send_word(in_w[j], 2);
         if (j == 10) begin
            iStart  = 1'b1;
            iLength = 12'd100;
            @(posedge iClk); #1;
            iStart  = 1'b0;
         end
      end
      iReset_n = 1'b0;
      @(posedge iClk); #1;
      @(negedge iClk);
      check("mid_rst_valid", {31'd0, oValid}, 32'd0);
      check("mid_rst_data",  oData,           32'd0);
      check("mid_rst_state", {30'd0, oDbgState}, {30'd0, IDLE});
      check("mid_rst_busy",  {31'd0, oBusy},  32'd0);
      check("mid_count", got_q.size(), 32'd29);
      for (int i = 0; i < 29; i++)
         if (i < got_q.size())
            check($sformatf("mid_w%0d", i), got_q[i], 32'(i * 3 + 7));
      check("mid_last_cnt",   last_cnt, 32'd0);
      check("mid_finish_cnt", fin_cnt,  32'd0);
      iReset_n = 1'b1;
      @(posedge iClk); #1;

      // L=36 (q=1, r=4) with gaps after the reset
      exp_q.delete();
      for (int j = 0; j < 64; j++) in_w[j] = 32'h8000_0001;
      for (int i = 0; i < 62; i++) exp_q.push_back(32'h0000_0018);
      exp_q.push_back(32'h0000_0010);
      exp_q.push_back(32'h0);
      run_frame("l36", 12'd36, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
